uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one-byte holding register in front of a shift register, sends 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency: the start bit begins on the first rising edge after the accept edge when idle; queued bytes follow with no gap.
// Backpressure: ready = holding register empty (registered); valid while ready=0 is ignored and upstream stalls.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   uart_out_data     byte to transmit, captured when valid && ready
//   valid / ready     upstream handshake
//   tx                registered serial line, idle high
//   busy              frame in progress or byte held
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_out_data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic accept;
    logic bit_end;
    logic load;

    assign ready   = ~hold_full_q;
    assign accept  = valid & ~hold_full_q;
    assign bit_end = (baud_q == '0);
    assign tx      = tx_q;
    assign busy    = (state_q != IDLE) | hold_full_q;

    // The shifter is loaded from the holding register either from idle or at the
    // last cycle of a stop bit. Loading needs hold_full_q=1 while accepting needs
    // hold_full_q=0, so the two can never hit the holding register together.
    assign load = hold_full_q & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_d      = baud_q;
        tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif

        if (accept) begin
            hold_d      = uart_out_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    baud_d    = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // A queued byte overrides this below; otherwise the line idles.
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            baud_d      = BAUD_RELOAD;
`ifdef UART_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_q      <= baud_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] uart_out_data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_out_data(uart_out_data),
        .valid(valid),
        .ready(ready),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Frame bit b of byte d: start, 8 data bits LSB first, optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // ---------------- reference model: per-cycle queue of line samples ----------------
    logic line_q[$];
    logic held = 1'b0;
    logic [7:0] held_byte = 8'h00;
    logic m_tx = 1'b1;
    logic m_ready = 1'b1;
    logic m_busy = 1'b0;
    logic chk_en = 1'b0;

    task automatic push_frame(input logic [7:0] d);
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++)
                line_q.push_back(exp_bit(d, b));
    endtask

    always @(posedge clk) begin
        logic acc;
        logic in_frame;
        if (!rst_n) begin
            line_q.delete();
            held    = 1'b0;
            m_tx    = 1'b1;
            m_ready = 1'b1;
            m_busy  = 1'b0;
        end else begin
            acc = valid && !held;
            if (line_q.size() == 0 && held) begin
                push_frame(held_byte);
                held = 1'b0;
            end
            if (line_q.size() > 0) begin
                m_tx = line_q.pop_front();
                in_frame = 1'b1;
            end else begin
                m_tx = 1'b1;
                in_frame = 1'b0;
            end
            if (acc) begin
                held = 1'b1;
                held_byte = uart_out_data;
            end
            m_ready = !held;
            m_busy  = in_frame || held;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tx", tx, m_tx);
            chk("model_ready", ready, m_ready);
            chk("model_busy", busy, m_busy);
        end
    end

    // ---------------- helpers ----------------
    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        valid = 1'b1;
        uart_out_data = d;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", ready, 1'b1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic check_frame(input string nm, input logic [7:0] d);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk(nm, tx, exp_bit(d, i / CPB));
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // bit 0 is sent first
        int          nbits;
    } vec_t;

    localparam int NV = 9;
    vec_t vt[NV];
    logic cap[3*FL];

    initial begin
`ifdef UART_TX_PARITY_EN
        vt[0] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 11};
        vt[1] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vt[2] = '{8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 11};
        vt[3] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11};
        vt[4] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 11};
        vt[5] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11};
        vt[6] = '{8'h03, {1'b1, 1'b0, 8'h03, 1'b0}, 11};
        vt[7] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}, 11};
        vt[8] = '{8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 11};
`else
        vt[0] = '{8'h55, {2'b01, 8'h55, 1'b0}, 10};
        vt[1] = '{8'hA5, {2'b01, 8'hA5, 1'b0}, 10};
        vt[2] = '{8'h3C, {2'b01, 8'h3C, 1'b0}, 10};
        vt[3] = '{8'hFF, {2'b01, 8'hFF, 1'b0}, 10};
        vt[4] = '{8'h00, {2'b01, 8'h00, 1'b0}, 10};
        vt[5] = '{8'h07, {2'b01, 8'h07, 1'b0}, 10};
        vt[6] = '{8'h03, {2'b01, 8'h03, 1'b0}, 10};
        vt[7] = '{8'h80, {2'b01, 8'h80, 1'b0}, 10};
        vt[8] = '{8'h01, {2'b01, 8'h01, 1'b0}, 10};
`endif

        // reset state
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // single frames from idle: held for exactly one cycle, then the exact waveform
        for (int k = 0; k < NV; k++) begin
            wait_idle();
            send(vt[k].data);
            chk("tbl_held_ready", ready, 1'b0);
            chk("tbl_held_tx", tx, 1'b1);
            chk("tbl_held_busy", busy, 1'b1);
            for (int i = 0; i < vt[k].nbits * CPB; i++) begin
                @(negedge clk);
                chk("tbl_bit", tx, vt[k].frame[i / CPB]);
                if (i == 0) chk("tbl_ready_after_load", ready, 1'b1);
                if (i == vt[k].nbits * CPB - 1) chk("tbl_busy_in_stop", busy, 1'b1);
            end
            @(negedge clk);
            chk("tbl_idle_busy", busy, 1'b0);
            chk("tbl_idle_tx", tx, 1'b1);
        end

        // back-to-back: 0x3C queued during 0xA5 data, 0xC3 held off while queue full
        wait_idle();
        send(8'hA5);
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk);
            cap[i] = tx;
            if (i == 10) begin
                valid = 1'b1;
                uart_out_data = 8'h3C;
            end
            if (i == 11) begin
                valid = 1'b0;
                chk("b2b_queued_ready", ready, 1'b0);
            end
            if (i == 20) begin
                valid = 1'b1;
                uart_out_data = 8'hC3;
            end
            if (i >= 21 && i < FL) chk("b2b_stall_ready", ready, 1'b0);
            if (i == FL) chk("b2b_ready_on_load", ready, 1'b1);
            if (i == FL + 1) begin
                valid = 1'b0;
                chk("b2b_third_held", ready, 1'b0);
            end
        end
        for (int i = 0; i < 3 * FL; i++) begin
            logic [7:0] d;
            d = (i < FL) ? 8'hA5 : ((i < 2 * FL) ? 8'h3C : 8'hC3);
            chk("b2b_line", cap[i], exp_bit(d, (i % FL) / CPB));
        end
        @(negedge clk);
        chk("b2b_idle", busy, 1'b0);

        // reset during data bit 3 of 0xFF, then a clean frame of 0x00
        send(8'hFF);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_tx", tx, 1'b1);
        send(8'h00);
        check_frame("postrst_frame", 8'h00);
        @(negedge clk);
        chk("postrst_idle", busy, 1'b0);

        // random traffic and occasional resets, checked by the background model
        for (int i = 0; i < 2500; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            uart_out_data = 8'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        wait_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
